// File: rtl/permute_pkg.sv
// Shared types and helpers for the programmable bit-permutation engine.
// Used by permute_engine and permute_round.
package permute_pkg;

  localparam int unsigned MAX_WIDTH = 256;
  localparam int unsigned MAX_IDX_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [MAX_WIDTH-1:0][MAX_IDX_W-1:0] full_map_t;

  // map[i] = i for the first `width` entries; unused entries are zero.
  function automatic full_map_t identity_map(input int unsigned width);
    full_map_t m;
    m = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) m[i] = MAX_IDX_W'(i);
    end
    return m;
  endfunction

  // A request of 0 rounds runs once; requests above the maximum saturate.
  function automatic int unsigned clamp_rounds(input int unsigned rounds,
                                               input int unsigned max_rounds);
    if (rounds == 0) return 1;
    if (rounds > max_rounds) return max_rounds;
    return rounds;
  endfunction

endpackage

// File: rtl/permute_round.sv
// One combinational permutation round: forward gathers nxt[i] = cur[map[i]],
// inverse scatters nxt[map[i]] = cur[i] with the highest i winning collisions.
module permute_round
  import permute_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [0:WIDTH-1]            i_cur,
  input  logic [WIDTH-1:0][IDX_W-1:0] i_map,
  input  logic                        i_inverse,
  output logic [0:WIDTH-1]            o_nxt
);

  // Zero default keeps untouched bits of a non-bijective inverse at 0.
  always_comb begin
    o_nxt = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_inverse) o_nxt[i_map[i]] = i_cur[i];
      else           o_nxt[i]        = i_cur[i_map[i]];
    end
  end

endmodule

// File: rtl/permute_engine.sv
// Programmable WIDTH-bit permutation engine with valid/ready handshakes.
// Optional map bijection check: define PERMUTE_BIJECTION_CHECK_EN.
module permute_engine
  import permute_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned IDX_W      = $clog2(WIDTH),
  parameter int unsigned MAX_ROUNDS = 8,
  parameter int unsigned RND_W      = $clog2(MAX_ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:WIDTH-1] in_data,
  input  logic             cfg_inverse,
  input  logic [RND_W-1:0] cfg_rounds,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] out_data,
  input  logic             map_wr_en,
  input  logic [IDX_W-1:0] map_wr_addr,
  input  logic [IDX_W-1:0] map_wr_data,
  output logic             map_err,
  output logic             busy
`ifdef PERMUTE_BIJECTION_CHECK_EN
  ,
  output logic             map_ok
`endif
);

  localparam full_map_t ID_FULL = identity_map(WIDTH);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [WIDTH-1:0][IDX_W-1:0] r_map;
  logic [0:WIDTH-1]            r_cur;
  logic [0:WIDTH-1]            w_nxt;
  logic                        r_inv;
  logic [RND_W-1:0]            r_rounds;
  logic [RND_W-1:0]            r_cnt;
  logic                        r_pend_vld;
  logic [IDX_W-1:0]            r_pend_addr;
  logic [IDX_W-1:0]            r_pend_data;
  logic                        r_in_ready;
  logic                        r_out_valid;
  logic                        r_busy;
  logic                        r_map_err;
  logic                        w_in_ready_nxt;
  logic                        w_out_valid_nxt;
  logic                        w_busy_nxt;
  logic                        w_map_err_nxt;
  logic                        w_map_ok_nxt;
  logic                        w_accept;
  logic                        w_map_wr_ok;
  logic                        w_last;
  logic                        w_release;

  assign w_accept    = (r_state == IDLE) && in_valid && r_in_ready;
  assign w_map_wr_ok = map_wr_en && (r_state == IDLE);
  assign w_last      = (r_cnt == (r_rounds - RND_W'(1)));
  assign w_release   = (r_state == DONE) && out_ready;

`ifdef PERMUTE_BIJECTION_CHECK_EN
  logic [WIDTH-1:0] w_cov;
  logic             r_map_ok;

  // Every index must be the source of at least one entry.
  always_comb begin
    w_cov = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_cov = w_cov | (WIDTH'(1) << r_map[i]);
    end
  end

  assign w_map_ok_nxt = &w_cov;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_map_ok <= 1'b1;
    else        r_map_ok <= w_map_ok_nxt;
  end

  assign map_ok = r_map_ok;
`else
  assign w_map_ok_nxt = 1'b1;
`endif

  permute_round #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_round (
    .i_cur     (r_cur),
    .i_map     (r_map),
    .i_inverse (r_inv),
    .o_nxt     (w_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic, evaluated one cycle ahead so the ports come from flops.
  always_comb begin
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    w_busy_nxt      = 1'b0;
    w_map_err_nxt   = map_wr_en && (r_state != IDLE);
    case (w_state_nxt)
      IDLE:    w_in_ready_nxt  = w_map_ok_nxt;
      RUN:     w_busy_nxt      = 1'b1;
      DONE: begin
        w_out_valid_nxt = 1'b1;
        w_busy_nxt      = 1'b1;
      end
      default: w_in_ready_nxt  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_map_err   <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_map_err   <= w_map_err_nxt;
    end
  end

  // Block register: loaded on accept, permuted once per RUN cycle, held in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur    <= '0;
      r_inv    <= 1'b0;
      r_rounds <= RND_W'(1);
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_cur    <= in_data;
      r_inv    <= cfg_inverse;
      r_rounds <= RND_W'(clamp_rounds(32'(cfg_rounds), MAX_ROUNDS));
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_cur <= w_nxt;
      r_cnt <= w_last ? '0 : (r_cnt + RND_W'(1));
    end
  end

  // A write coinciding with an accept is parked until the block leaves DONE,
  // so the in-flight block keeps the map it was accepted with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        r_map[i] <= ID_FULL[i][IDX_W-1:0];
      end
      r_pend_vld  <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
    end else begin
      if (w_map_wr_ok) begin
        if (w_accept) begin
          r_pend_vld  <= 1'b1;
          r_pend_addr <= map_wr_addr;
          r_pend_data <= map_wr_data;
        end else begin
          r_map[map_wr_addr] <= map_wr_data;
        end
      end
      if (w_release && r_pend_vld) begin
        r_map[r_pend_addr] <= r_pend_data;
        r_pend_vld         <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_cur;
  assign map_err   = r_map_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_permute_engine.sv
// Self-checking bench for permute_engine (WIDTH=8) with a bit-array reference model.
module tb_permute_engine;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned MAX_ROUNDS = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned RND_W      = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [0:WIDTH-1] in_data;
  logic             cfg_inverse;
  logic [RND_W-1:0] cfg_rounds;
  logic             out_valid;
  logic             out_ready;
  logic [0:WIDTH-1] out_data;
  logic             map_wr_en;
  logic [IDX_W-1:0] map_wr_addr;
  logic [IDX_W-1:0] map_wr_data;
  logic             map_err;
  logic             busy;
`ifdef PERMUTE_BIJECTION_CHECK_EN
  logic             map_ok;
`endif

  int n_vec = 0;
  int n_err = 0;
  int mdl_map [8];

  always #5 clk = ~clk;

  permute_engine #(
    .WIDTH      (WIDTH),
    .MAX_ROUNDS (MAX_ROUNDS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .cfg_inverse (cfg_inverse),
    .cfg_rounds  (cfg_rounds),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .map_wr_en   (map_wr_en),
    .map_wr_addr (map_wr_addr),
    .map_wr_data (map_wr_data),
    .map_err     (map_err),
    .busy        (busy)
`ifdef PERMUTE_BIJECTION_CHECK_EN
    ,
    .map_ok      (map_ok)
`endif
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference: bit 0 is the MSB, so model index i maps to vector bit 7-i.
  function automatic logic [7:0] mdl_round(input logic [7:0] v, input bit inv);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (!inv) r[7-i] = v[7-mdl_map[i]];
      else      r[7-mdl_map[i]] = v[7-i];
    end
    return r;
  endfunction

  function automatic int eff_rounds(input int r);
    if (r == 0) return 1;
    if (r > 8) return 8;
    return r;
  endfunction

  function automatic logic [7:0] mdl_run(input logic [7:0] v, input bit inv, input int r);
    logic [7:0] x;
    x = v;
    for (int k = 0; k < eff_rounds(r); k++) x = mdl_round(x, inv);
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic map_write(input int a, input int d, input bit lands);
    map_wr_en   = 1'b1;
    map_wr_addr = IDX_W'(a);
    map_wr_data = IDX_W'(d);
    tick();
    map_wr_en = 1'b0;
    if (lands) mdl_map[a] = d;
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    check(tag, 32'(in_ready), 32'(1));
  endtask

  task automatic start_block(input logic [7:0] d, input bit inv, input int r,
                             output logic [7:0] exp);
    wait_ready("ready_wait");
    exp         = mdl_run(d, inv, r);
    in_valid    = 1'b1;
    in_data     = d;
    cfg_inverse = inv;
    cfg_rounds  = RND_W'(r);
    tick();
    in_valid = 1'b0;
    check("in_ready_in_run", 32'(in_ready), 32'(0));
    check("busy_in_run", 32'(busy), 32'(1));
  endtask

  // `already` is how many edges have passed since the accept edge.
  task automatic finish_block(input string tag, input logic [7:0] exp, input int r,
                              input int already, input int hold);
    int k;
    logic [7:0] held;
    k = already;
    while (out_valid !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_latency"}, 32'(k), 32'(eff_rounds(r)));
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_data"}, 32'(out_data), 32'(held));
      check({tag, "_hold_valid"}, 32'(out_valid), 32'(1));
      check({tag, "_hold_in_ready"}, 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'(0));
    check({tag, "_busy_drop"}, 32'(busy), 32'(0));
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    map_wr_en   = 1'b0;
    map_wr_addr = '0;
    map_wr_data = '0;
    in_data     = '0;
    cfg_inverse = 1'b0;
    cfg_rounds  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mdl_map[i] = i;
  endtask

  initial begin
    logic [7:0] exp;
    logic [7:0] d;
    int         r;
    bit         inv;
    int         p [8];
    int         j;
    int         t;

    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_map_err", 32'(map_err), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));

    // Identity map after reset.
    start_block(8'hA5, 1'b0, 3, exp);
    finish_block("ident", 8'hA5, 3, 0, 0);

    // Bit reversal.
    for (int i = 0; i < 8; i++) map_write(i, 7 - i, 1'b1);
    start_block(8'b1100_0001, 1'b0, 1, exp);
    finish_block("rev1", 8'b1000_0011, 1, 0, 0);
    start_block(8'b1100_0001, 1'b0, 2, exp);
    finish_block("rev2", 8'b1100_0001, 2, 0, 0);

    // Rotation, forward/inverse, zero and saturated round counts.
    for (int i = 0; i < 8; i++) map_write(i, (i + 1) % 8, 1'b1);
    start_block(8'h80, 1'b0, 1, exp);
    finish_block("rot_fwd", 8'h01, 1, 0, 0);
    start_block(8'h01, 1'b1, 1, exp);
    finish_block("rot_inv", 8'h80, 1, 0, 0);
    start_block(8'h80, 1'b0, 0, exp);
    finish_block("rot_r0", 8'h01, 0, 0, 0);
    start_block(8'h80, 1'b0, 15, exp);
    finish_block("rot_sat", 8'h80, 15, 0, 0);

    // Map write during RUN is rejected.
    start_block(8'h80, 1'b0, 4, exp);
    map_write(0, 5, 1'b0);
    check("map_err_pulse", 32'(map_err), 32'(1));
    tick();
    check("map_err_clear", 32'(map_err), 32'(0));
    finish_block("run_write", 8'h08, 4, 2, 0);

    // Write on the accept edge: current block uses the old map.
    wait_ready("ready_wait");
    in_valid    = 1'b1;
    in_data     = 8'h80;
    cfg_inverse = 1'b0;
    cfg_rounds  = RND_W'(1);
    map_wr_en   = 1'b1;
    map_wr_addr = IDX_W'(0);
    map_wr_data = IDX_W'(0);
    tick();
    in_valid  = 1'b0;
    map_wr_en = 1'b0;
    mdl_map[0] = 0;
    finish_block("accept_write", 8'h01, 1, 0, 0);
`ifndef PERMUTE_BIJECTION_CHECK_EN
    start_block(8'h80, 1'b0, 1, exp);
    finish_block("new_map_fwd", 8'h81, 1, 0, 0);
    start_block(8'hFF, 1'b1, 1, exp);
    finish_block("nonbij_inv", 8'hBF, 1, 0, 0);
`endif
    map_write(0, 1, 1'b1);

    // Backpressure hold.
    start_block(8'h3C, 1'b1, 2, exp);
    finish_block("backpressure", exp, 2, 0, 10);

    // Reset during RUN discards the block and restores identity.
    start_block(8'h5A, 1'b0, 8, exp);
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) mdl_map[i] = i;
    start_block(8'h96, 1'b0, 5, exp);
    finish_block("post_rst_ident", 8'h96, 5, 0, 0);

`ifdef PERMUTE_BIJECTION_CHECK_EN
    map_write(3, 2, 1'b1);
    map_write(5, 2, 1'b1);
    tick();
    check("bij_map_ok_low", 32'(map_ok), 32'(0));
    check("bij_in_ready_low", 32'(in_ready), 32'(0));
    map_write(3, 3, 1'b1);
    map_write(5, 5, 1'b1);
    tick();
    check("bij_map_ok_high", 32'(map_ok), 32'(1));
    check("bij_in_ready_high", 32'(in_ready), 32'(1));
`endif

    // Randomized blocks against the reference model.
    for (int it = 0; it < 30; it++) begin
      t = int'($urandom_range(0, 3));
      if (t == 1 || t == 2) begin
        for (int i = 0; i < 8; i++) p[i] = i;
        for (int i = 7; i > 0; i--) begin
          j = int'($urandom_range(0, i));
          {p[i], p[j]} = {p[j], p[i]};
        end
        for (int i = 0; i < 8; i++) map_write(i, p[i], 1'b1);
      end
`ifndef PERMUTE_BIJECTION_CHECK_EN
      else if (t == 3) begin
        for (int i = 0; i < 3; i++) map_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b1);
      end
`endif
      d   = 8'($urandom);
      inv = 1'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 15));
      start_block(d, inv, r, exp);
      finish_block("random", exp, r, 0, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
